msdap_out_serializer: RTL and testbench
=======================================

MSDAP_OUT_SERIALIZER -- requirements
Module: msdap_out_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 40, bits per output word per channel.
REQ-002 SHALL have parameter DEPTH, default 2, result-pair buffer entries.
REQ-003 SHALL have port SCLK  input  1  system clock (26.88 MHz); all logic is on the rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort: discard the current word and empty the buffer.
REQ-006 SHALL have port res_valid  input  1  result pair present on res_L/res_R this cycle.
REQ-007 SHALL have port res_L  input  WIDTH  left-channel filter result, two's complement.
REQ-008 SHALL have port res_R  input  WIDTH  right-channel filter result, two's complement.
REQ-009 SHALL have port res_ready  output  1  buffer can accept a pair.
REQ-010 SHALL have port OutputL  output  1  left serial data, MSB first.
REQ-011 SHALL have port OutputR  output  1  right serial data, MSB first.
REQ-012 SHALL have port OutReady  output  1  high while OutputL/OutputR carry valid bits.
REQ-013 SHALL have port word_done  output  1  one-cycle pulse in the cycle after the LSB is presented.
REQ-014 SHALL have port overflow  output  1  sticky flag: a pair was dropped.
REQ-015 SHALL have port words_sent  output  16  count of completed words, wraps at 65535->0.

Function
REQ-016 SHALL hold accepted pairs in a DEPTH-entry FIFO; a push occurs when res_valid=1 and res_ready=1.
REQ-017 SHALL drive res_ready = (registered count < DEPTH), so a pop in the same cycle does not raise it.
REQ-018 SHALL drop a pair offered with res_valid=1 while res_ready=0, leave FIFO contents unchanged, and set overflow.
REQ-019 SHALL implement FSM states IDLE, LOAD and SHIFT.
REQ-020 IDLE SHALL go to LOAD when the FIFO is non-empty.
REQ-021 LOAD SHALL pop the FIFO head into the L/R shift registers, load bit counter = WIDTH-1, and go to SHIFT.
REQ-022 SHIFT SHALL present bit[counter] on OutputL/OutputR with OutReady=1 for exactly WIDTH consecutive cycles, bit WIDTH-1 first.
REQ-023 In SHIFT, the bit counter SHALL decrement by one per cycle.
REQ-024 Outputs OutputL, OutputR and OutReady SHALL be registered, changing only after a rising SCLK edge.
REQ-025 A receiver sampling on the rising edge SHALL see each bit for one full cycle.
REQ-026 Latency SHALL be: a push into an empty FIFO in IDLE at edge N gives OutReady=1 with the MSB visible after edge N+2.
REQ-027 At counter=0, if the FIFO is non-empty, the next word SHALL be popped and its MSB presented on the immediately following cycle, with OutReady held high and no gap.
REQ-028 At counter=0, if the FIFO is empty, the block SHALL go to IDLE and OutReady SHALL be 0 the following cycle.
REQ-029 At word completion, word_done SHALL pulse once and words_sent SHALL increment modulo 2^16.
REQ-030 flush=1 SHALL, at the next edge, force IDLE, empty the FIFO, and drive OutReady=0, OutputL=0 and OutputR=0.
REQ-031 flush=1 SHALL retain overflow and words_sent, SHALL NOT count the aborted word, and SHALL ignore any push in that cycle.
REQ-032 When simultaneous with a LOAD/last-bit pop, a push SHALL be accepted if count<DEPTH at that edge.

Reset
REQ-033 Reset_n=0 SHALL immediately, without a clock, set the FSM to IDLE, FIFO count=0, shift registers=0, and bit counter=0.
REQ-034 Reset_n=0 SHALL immediately drive OutputL=0, OutputR=0, OutReady=0, word_done=0, overflow=0, words_sent=0 and res_ready=1.
REQ-035 Reset asserted mid-word SHALL abort the word; no partial bits SHALL appear after release.
REQ-036 Operation SHALL resume on the first rising edge after Reset_n returns to 1.

Verification
REQ-037 Single word: push L=40'h80_0000_0001, R=40'h7F_FFFF_FFFE into an idle block -> after 2 edges, 40 cycles of OutReady=1 capture those exact values; one word_done; words_sent=1.
REQ-038 Back-to-back: push 3 pairs one cycle apart -> third push accepted; OutReady high for 120 contiguous cycles; words_sent=3; overflow=0.
REQ-039 Overflow: keep res_valid=1 for 4 cycles while idle with DEPTH=2 -> 3 pairs accepted (2 buffered + 1 loaded); 4th dropped; overflow=1 and stays 1.
REQ-040 Flush mid-word: flush at bit 20 of word 1 with 1 pair buffered -> OutReady=0 next cycle; buffer empty; words_sent unchanged; next push serialises cleanly.
REQ-041 Async reset mid-word: Reset_n low between edges at bit 10 -> outputs 0 before the next edge; after release, no output until a new push.
REQ-042 Wrap: preset/run 65536 words -> words_sent returns to 0 exactly once.

Source files
------------

// File: rtl/msdap_out_serializer.sv
// msdap_out_serializer: buffers filter result pairs in a small FIFO and shifts
// each pair out MSB-first on two serial lines, back-to-back when data is queued.
module msdap_out_serializer #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             SCLK,
    input  logic             Reset_n,
    input  logic             flush,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_L,
    input  logic [WIDTH-1:0] res_R,
    output logic             res_ready,
    output logic             OutputL,
    output logic             OutputR,
    output logic             OutReady,
    output logic             word_done,
    output logic             overflow,
    output logic [15:0]      words_sent
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem_l [DEPTH];
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd, wr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sh_l, sh_r;
    logic [BW-1:0]    cnt;
    logic             push, pop, last;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign res_ready = count < CW'(DEPTH);
    assign last      = state == SHIFT && cnt == '0;
    // The head is popped on the edge leaving IDLE, or on the LSB edge to chain words without a gap.
    assign pop       = !flush && count != '0 && (state == IDLE || last);
    assign push      = !flush && res_valid && res_ready;

    always_ff @(posedge SCLK) begin
        if (push) begin
            mem_l[wr] <= res_L;
            mem_r[wr] <= res_R;
        end
    end

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            rd         <= '0;
            wr         <= '0;
            count      <= '0;
            sh_l       <= '0;
            sh_r       <= '0;
            cnt        <= '0;
            OutputL    <= 1'b0;
            OutputR    <= 1'b0;
            OutReady   <= 1'b0;
            word_done  <= 1'b0;
            overflow   <= 1'b0;
            words_sent <= '0;
        end else if (flush) begin
            state     <= IDLE;
            rd        <= '0;
            wr        <= '0;
            count     <= '0;
            cnt       <= '0;
            OutputL   <= 1'b0;
            OutputR   <= 1'b0;
            OutReady  <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= last;
            if (last) words_sent <= words_sent + 16'd1;
            if (res_valid && !res_ready) overflow <= 1'b1;
            if (push) wr <= inc(wr);
            if (pop) begin
                rd   <= inc(rd);
                sh_l <= mem_l[rd];
                sh_r <= mem_r[rd];
                cnt  <= BW'(WIDTH - 1);
            end
            count <= count + CW'(push) - CW'(pop);
            case (state)
                IDLE: if (pop) state <= LOAD;
                LOAD: begin
                    state    <= SHIFT;
                    OutReady <= 1'b1;
                    OutputL  <= sh_l[WIDTH-1];
                    OutputR  <= sh_r[WIDTH-1];
                end
                SHIFT: begin
                    if (!last) begin
                        cnt     <= cnt - 1'b1;
                        OutputL <= sh_l[cnt-1'b1];
                        OutputR <= sh_r[cnt-1'b1];
                    end else if (pop) begin
                        OutputL <= mem_l[rd][WIDTH-1];
                        OutputR <= mem_r[rd][WIDTH-1];
                    end else begin
                        state    <= IDLE;
                        OutReady <= 1'b0;
                        OutputL  <= 1'b0;
                        OutputR  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msdap_out_serializer.sv
// tb_msdap_out_serializer: directed and random stimulus checked every cycle
// against a queue-based reference model of the serializer.
module tb_msdap_out_serializer;
    localparam int W = 40;
    localparam int D = 2;

    logic         SCLK = 1'b0;
    logic         Reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         res_valid = 1'b0;
    logic [W-1:0] res_L = '0;
    logic [W-1:0] res_R = '0;
    logic         res_ready, OutputL, OutputR, OutReady, word_done, overflow;
    logic [15:0]  words_sent;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue of buffered pairs plus the word on the wire
    logic [W-1:0] q_l[$], q_r[$];
    logic [W-1:0] cur_l, cur_r;
    int           ph;
    int           k;
    logic         e_wd, e_ovf;
    logic [15:0]  e_sent;

    logic [W-1:0] cap_l, cap_r;
    int           cap_n;

    msdap_out_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .SCLK(SCLK), .Reset_n(Reset_n), .flush(flush), .res_valid(res_valid),
        .res_L(res_L), .res_R(res_R), .res_ready(res_ready), .OutputL(OutputL),
        .OutputR(OutputR), .OutReady(OutReady), .word_done(word_done),
        .overflow(overflow), .words_sent(words_sent)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_l.delete();
        q_r.delete();
        ph = 0;
        k = 0;
        e_wd = 1'b0;
        e_ovf = 1'b0;
        e_sent = '0;
    endtask

    task automatic model_step();
        bit rdy;
        rdy = q_l.size() < D;
        e_wd = 1'b0;
        if (flush) begin
            q_l.delete();
            q_r.delete();
            ph = 0;
        end else begin
            if (ph == 0) begin
                if (q_l.size() > 0) begin
                    cur_l = q_l.pop_front();
                    cur_r = q_r.pop_front();
                    ph = 1;
                end
            end else if (ph == 1) begin
                ph = 2;
                k = W - 1;
            end else if (k > 0) begin
                k--;
            end else begin
                e_wd = 1'b1;
                e_sent++;
                if (q_l.size() > 0) begin
                    cur_l = q_l.pop_front();
                    cur_r = q_r.pop_front();
                    k = W - 1;
                end else ph = 0;
            end
            if (res_valid) begin
                if (rdy) begin
                    q_l.push_back(res_L);
                    q_r.push_back(res_R);
                end else e_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("res_ready", 64'(res_ready), 64'(q_l.size() < D));
        chk("OutReady", 64'(OutReady), 64'(ph == 2));
        chk("OutputL", 64'(OutputL), 64'(ph == 2 ? cur_l[k] : 1'b0));
        chk("OutputR", 64'(OutputR), 64'(ph == 2 ? cur_r[k] : 1'b0));
        chk("word_done", 64'(word_done), 64'(e_wd));
        chk("overflow", 64'(overflow), 64'(e_ovf));
        chk("words_sent", 64'(words_sent), 64'(e_sent));
    endtask

    task automatic cyc();
        @(posedge SCLK);
        model_step();
        #1;
        if (OutReady) begin
            cap_l = {cap_l[W-2:0], OutputL};
            cap_r = {cap_r[W-2:0], OutputR};
            cap_n++;
        end
        check_all();
    endtask

    task automatic push1(input logic [W-1:0] l, input logic [W-1:0] r);
        res_valid = 1'b1;
        res_L = l;
        res_R = r;
        cyc();
        res_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [W-1:0] l0, r0;
        model_reset();
        #1;
        check_all();
        #11 Reset_n = 1'b1;
        run(2);

        // single word with exact capture
        cap_n = 0;
        push1(40'h80_0000_0001, 40'h7F_FFFF_FFFE);
        run(45);
        chk("single_bits", 64'(cap_n), 64'(W));
        chk("single_L", 64'(cap_l), 64'h80_0000_0001);
        chk("single_R", 64'(cap_r), 64'h7F_FFFF_FFFE);
        chk("single_sent", 64'(words_sent), 64'd1);

        // back-to-back: three pairs one cycle apart stream as 120 contiguous bits
        cap_n = 0;
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_L = rnd();
            res_R = rnd();
            cyc();
        end
        res_valid = 1'b0;
        run(125);
        chk("b2b_bits", 64'(cap_n), 64'(3 * W));
        chk("b2b_sent", 64'(words_sent), 64'd4);
        chk("b2b_ovf", 64'(overflow), 64'd0);

        // flush mid-word with one pair buffered
        push1(rnd(), rnd());
        push1(rnd(), rnd());
        for (int i = 0; i < 100 && !(ph == 2 && k == W - 1 - 20); i++) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_oready", 64'(OutReady), 64'd0);
        chk("flush_sent", 64'(words_sent), 64'd4);
        run(5);
        cap_n = 0;
        l0 = rnd();
        r0 = rnd();
        push1(l0, r0);
        run(45);
        chk("post_flush_L", 64'(cap_l), 64'(l0));
        chk("post_flush_R", 64'(cap_r), 64'(r0));
        chk("post_flush_sent", 64'(words_sent), 64'd5);

        // asynchronous reset between edges mid-word
        push1(rnd(), rnd());
        for (int i = 0; i < 100 && !(ph == 2 && k == W - 1 - 10); i++) cyc();
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge SCLK);
        #2 Reset_n = 1'b1;
        run(10);

        // overflow: valid held four cycles from idle
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_L = rnd();
            res_R = rnd();
            cyc();
        end
        res_valid = 1'b0;
        chk("ovf_set", 64'(overflow), 64'd1);
        run(130);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_sent", 64'(words_sent), 64'd3);

        // random traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            res_valid = $urandom_range(0, 2) == 0;
            res_L = rnd();
            res_R = rnd();
            flush = $urandom_range(0, 99) == 0;
            cyc();
        end
        res_valid = 1'b0;
        flush = 1'b0;
        run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
